// File: rtl/ram_arbiter_2p.sv
// ---------------------------------------------------------------------------
// ram_arbiter_2p
//
// Shares one single-port, byte-write, read-first word RAM between the core's
// instruction-fetch port and its data port. At most one access is granted per
// cycle; the grant is combinational from the requests. The RAM output is
// registered inside the RAM, so the response for a grant in cycle N is
// presented on the granted port in cycle N+1. Accesses whose word address
// lies beyond the RAM are still granted, but they never write the RAM and
// they return err=1 with zero data.
//
// Build option:
//   RAM_ARB_ROUND_ROBIN_EN  defined   : a last-winner pointer alternates
//                                       priority when both ports request.
//                           undefined : fixed priority, data over instruction.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   i_req/i_addr              instruction request, byte address
//   i_gnt                     instruction request accepted this cycle
//   i_rvalid/i_rdata/i_err    instruction response (one cycle after grant)
//   d_req/d_we/d_addr/d_wdata data request; d_we==0 means read
//   d_gnt                     data request accepted this cycle
//   d_rvalid/d_rdata/d_err    data response (also issued for writes)
//   ram_we/ram_addr/ram_di    to the RAM
//   ram_dout                  registered RAM read data
// ---------------------------------------------------------------------------
module ram_arbiter_2p #(
  parameter  int MEM_SIZE_WORDS = 4096,
  localparam int ADDR_WIDTH     = $clog2(MEM_SIZE_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [31:0]           i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [31:0]           i_rdata,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic [3:0]            d_we,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  d_err,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_di,
  input  logic [31:0]           ram_dout
);

  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,
    RESP_INSTR = 2'd1,
    RESP_DATA  = 2'd2
  } resp_sel_t;

  localparam logic [31:0] MEM_WORDS = 32'(MEM_SIZE_WORDS);

  // True when the word part of a byte address falls inside the RAM.
  function automatic logic addr_in_range(input logic [31:0] addr);
    return ({2'b00, addr[31:2]} < MEM_WORDS);
  endfunction

  // RAM word index of a byte address; the byte offset is ignored.
  function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [31:0] addr);
    return addr[ADDR_WIDTH+1:2];
  endfunction

  logic      i_win_s;
  logic      d_win_s;
  logic      grant_err_s;
  resp_sel_t next_sel_s;
  resp_sel_t resp_sel_r;
  logic      resp_err_r;

  // Byte-offset bits take no part in addressing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // 1 when the data port won the most recent grant, 0 for instruction.
  logic last_data_r;

  // Last-winner pointer; moves only when something is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_data_r <= 1'b0;
    end else if (d_win_s) begin
      last_data_r <= 1'b1;
    end else if (i_win_s) begin
      last_data_r <= 1'b0;
    end else begin
      last_data_r <= last_data_r;
    end
  end
`endif

  // Arbitration: pick at most one winner this cycle; nothing while in reset.
  always_comb begin
    i_win_s = 1'b0;
    d_win_s = 1'b0;
    if (rst) begin
      i_win_s = 1'b0;
      d_win_s = 1'b0;
    end else if (i_req && d_req) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      // The port that did not win last time goes first.
      if (last_data_r) begin
        i_win_s = 1'b1;
      end else begin
        d_win_s = 1'b1;
      end
`else
      d_win_s = 1'b1;
`endif
    end else begin
      i_win_s = i_req;
      d_win_s = d_req;
    end
  end

  assign i_gnt = i_win_s;
  assign d_gnt = d_win_s;

  // RAM drive for the winner; out-of-range accesses are granted but never write.
  always_comb begin
    ram_we      = 4'b0000;
    ram_addr    = {ADDR_WIDTH{1'b0}};
    ram_di      = 32'h0000_0000;
    grant_err_s = 1'b0;
    next_sel_s  = RESP_NONE;
    if (d_win_s) begin
      grant_err_s = !addr_in_range(d_addr);
      ram_addr    = word_index(d_addr);
      ram_di      = d_wdata;
      ram_we      = grant_err_s ? 4'b0000 : d_we;
      next_sel_s  = RESP_DATA;
    end else if (i_win_s) begin
      grant_err_s = !addr_in_range(i_addr);
      ram_addr    = word_index(i_addr);
      next_sel_s  = RESP_INSTR;
    end else begin
      next_sel_s  = RESP_NONE;
    end
  end

  // Remember which port was granted and whether it was out of range.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_sel_r <= RESP_NONE;
      resp_err_r <= 1'b0;
    end else begin
      resp_sel_r <= next_sel_s;
      resp_err_r <= grant_err_s;
    end
  end

  // Route the registered RAM data to the port granted last cycle. Reset
  // gating drops a response whose grant was followed directly by reset.
  always_comb begin
    i_rvalid = 1'b0;
    i_err    = 1'b0;
    i_rdata  = 32'h0000_0000;
    d_rvalid = 1'b0;
    d_err    = 1'b0;
    d_rdata  = 32'h0000_0000;
    if (rst) begin
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
    end else begin
      case (resp_sel_r)
        RESP_INSTR: begin
          i_rvalid = 1'b1;
          i_err    = resp_err_r;
          i_rdata  = resp_err_r ? 32'h0000_0000 : ram_dout;
        end
        RESP_DATA: begin
          d_rvalid = 1'b1;
          d_err    = resp_err_r;
          d_rdata  = resp_err_r ? 32'h0000_0000 : ram_dout;
        end
        default: begin
          i_rvalid = 1'b0;
          d_rvalid = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter_2p
//
// Testbench for ram_arbiter_2p with a behavioural read-first byte-write RAM
// attached. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge. A separate reference memory (ref_mem) holds
// the contents the RAM is expected to have. Follows RAM_ARB_ROUND_ROBIN_EN
// in the same way as the design.
// ---------------------------------------------------------------------------
module tb_ram_arbiter_2p;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_di;
  logic [31:0] ram_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_arbiter_2p #(.MEM_SIZE_WORDS(4096)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_dout(ram_dout)
  );

  // Behavioural RAM with a backdoor preload port.
  logic [31:0] ram_mem [0:4095];
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) begin
      ram_mem[pre_addr] <= pre_data;
    end else begin
      ram_dout <= ram_mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_di[8*b +: 8];
    end
  end

  logic [31:0] ref_mem [0:4095];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload_word(input int w, input logic [31:0] v);
    pre_en = 1'b1; pre_addr = 12'(w); pre_data = v; ref_mem[w] = v;
    step();
    pre_en = 1'b0;
  endtask

  task automatic preload_all();
    pre_en = 1'b1;
    for (int w = 0; w < 4096; w++) begin
      pre_addr = 12'(w); pre_data = $urandom; ref_mem[w] = pre_data;
      step();
    end
    pre_en = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    repeat (n) step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0)      return $urandom | 32'h0000_4000;       // beyond the RAM
    else if (k == 1) return 32'h0000_3FFC | 32'($urandom_range(0, 3)); // last word
    else if (k < 6)  return 32'($urandom_range(0, 63));     // hot window
    else             return 32'($urandom_range(0, 16383));
  endfunction

  task automatic test_reset();
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h10; d_addr = 32'h20;
    d_we = 4'hF; d_wdata = 32'h5555_AAAA;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin bad++;
        $display("FAIL reset_gnt: got i=%b d=%b want 0 0", i_gnt, d_gnt); end
      total++; if (ram_we !== 4'b0000) begin bad++;
        $display("FAIL reset_ram_we: got %b want 0000", ram_we); end
      total++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || i_err !== 1'b0 || d_err !== 1'b0) begin bad++;
        $display("FAIL reset_rvalid: got iv=%b dv=%b ie=%b de=%b want 0", i_rvalid, d_rvalid, i_err, d_err); end
      total++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin bad++;
        $display("FAIL reset_rdata: got i=%h d=%h want 0", i_rdata, d_rdata); end
    end
    step();
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 4'h0;
  endtask

  task automatic test_read();
    preload_word(5, 32'hDEAD_BEEF);
    i_req = 1'b1; i_addr = 32'h14;
    @(negedge clk);
    total++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin bad++;
      $display("FAIL read_gnt: got i=%b d=%b want 1 0", i_gnt, d_gnt); end
    total++; if (ram_addr !== 12'd5 || ram_we !== 4'b0000) begin bad++;
      $display("FAIL read_ram: got addr=%0d we=%b want 5 0000", ram_addr, ram_we); end
    step();
    i_req = 1'b0;
    @(negedge clk);
    total++; if (i_rvalid !== 1'b1 || i_rdata !== 32'hDEAD_BEEF || i_err !== 1'b0) begin bad++;
      $display("FAIL read_resp: got v=%b d=%h e=%b want 1 deadbeef 0", i_rvalid, i_rdata, i_err); end
    total++; if (d_rvalid !== 1'b0) begin bad++;
      $display("FAIL read_other: got d_rvalid=%b want 0", d_rvalid); end
    step();
    @(negedge clk);
    total++; if (i_rvalid !== 1'b0) begin bad++;
      $display("FAIL read_pulse: got i_rvalid=%b want 0", i_rvalid); end
    step();
  endtask

  task automatic test_byte_write();
    preload_word(2, 32'h1122_3344);
    d_req = 1'b1; d_we = 4'b0010; d_wdata = 32'h0000_AA00; d_addr = 32'h8;
    @(negedge clk);
    total++; if (d_gnt !== 1'b1 || ram_we !== 4'b0010 || ram_addr !== 12'd2 || ram_di !== 32'h0000_AA00) begin bad++;
      $display("FAIL bw_drive: got g=%b we=%b a=%0d di=%h want 1 0010 2 0000aa00", d_gnt, ram_we, ram_addr, ram_di); end
    step();
    d_we = 4'b0000; d_wdata = 32'h0;
    @(negedge clk);
    total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1122_3344 || d_err !== 1'b0) begin bad++;
      $display("FAIL bw_old: got v=%b d=%h e=%b want 1 11223344 0", d_rvalid, d_rdata, d_err); end
    step();
    d_req = 1'b0;
    ref_mem[2] = 32'h1122_AA44;
    @(negedge clk);
    total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1122_AA44) begin bad++;
      $display("FAIL bw_new: got v=%b d=%h want 1 1122aa44", d_rvalid, d_rdata); end
    step();
  endtask

  task automatic test_contention();
    int ng_i, ng_d;
    logic want_d;
    do_reset(1);
    ng_i = 0; ng_d = 0;
    i_req = 1'b1; i_addr = 32'h20; d_req = 1'b1; d_addr = 32'h24; d_we = 4'h0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
`ifdef RAM_ARB_ROUND_ROBIN_EN
      want_d = (c % 2 == 0);
`else
      want_d = 1'b1;
`endif
      total++; if (d_gnt !== want_d || i_gnt !== !want_d) begin bad++;
        $display("FAIL cont_cycle%0d: got i=%b d=%b want d=%b", c, i_gnt, d_gnt, want_d); end
      if (i_gnt === 1'b1) ng_i++;
      if (d_gnt === 1'b1) ng_d++;
      step();
    end
`ifdef RAM_ARB_ROUND_ROBIN_EN
    total++; if (ng_d != 2 || ng_i != 2) begin bad++;
      $display("FAIL cont_count: got d=%0d i=%0d want 2 2", ng_d, ng_i); end
`else
    total++; if (ng_d != 4 || ng_i != 0) begin bad++;
      $display("FAIL cont_count: got d=%0d i=%0d want 4 0", ng_d, ng_i); end
`endif
    i_req = 1'b0; d_req = 1'b0;
    step();
    // One cycle of simultaneous requests; instruction keeps holding.
    i_req = 1'b1; i_addr = 32'h20; d_req = 1'b1; d_addr = 32'h24;
    @(negedge clk);
    total++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin bad++;
      $display("FAIL pair_first: got i=%b d=%b want 0 1", i_gnt, d_gnt); end
    step();
    d_req = 1'b0;
    @(negedge clk);
    total++; if (i_gnt !== 1'b1 || d_rvalid !== 1'b1 || d_rdata !== ref_mem[9]) begin bad++;
      $display("FAIL pair_second: got ig=%b dv=%b dd=%h want 1 1 %h", i_gnt, d_rvalid, d_rdata, ref_mem[9]); end
    step();
    i_req = 1'b0;
    @(negedge clk);
    total++; if (i_rvalid !== 1'b1 || i_rdata !== ref_mem[8] || d_rvalid !== 1'b0) begin bad++;
      $display("FAIL pair_resp: got iv=%b id=%h dv=%b want 1 %h 0", i_rvalid, i_rdata, d_rvalid, ref_mem[8]); end
    step();
  endtask

  task automatic test_out_of_range();
    d_req = 1'b1; d_addr = 32'h0000_4000; d_we = 4'hF; d_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    total++; if (d_gnt !== 1'b1 || ram_we !== 4'b0000) begin bad++;
      $display("FAIL oor_drive: got g=%b we=%b want 1 0000", d_gnt, ram_we); end
    step();
    d_req = 1'b0; d_we = 4'h0;
    i_req = 1'b1; i_addr = 32'h0000_3FFC;
    @(negedge clk);
    total++; if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) begin bad++;
      $display("FAIL oor_resp: got v=%b e=%b d=%h want 1 1 0", d_rvalid, d_err, d_rdata); end
    total++; if (ram_mem[0] !== ref_mem[0]) begin bad++;
      $display("FAIL oor_ram: got word0=%h want %h", ram_mem[0], ref_mem[0]); end
    step();
    i_addr = 32'hFFFF_FFFC;
    @(negedge clk);
    total++; if (i_rvalid !== 1'b1 || i_err !== 1'b0 || i_rdata !== ref_mem[4095]) begin bad++;
      $display("FAIL last_word: got v=%b e=%b d=%h want 1 0 %h", i_rvalid, i_err, i_rdata, ref_mem[4095]); end
    step();
    i_req = 1'b0;
    @(negedge clk);
    total++; if (i_rvalid !== 1'b1 || i_err !== 1'b1 || i_rdata !== 32'h0) begin bad++;
      $display("FAIL oor_instr: got v=%b e=%b d=%h want 1 1 0", i_rvalid, i_err, i_rdata); end
    step();
  endtask

  task automatic test_reset_mid();
    i_req = 1'b1; i_addr = 32'h14;
    @(negedge clk);
    total++; if (i_gnt !== 1'b1) begin bad++;
      $display("FAIL rmid_gnt: got %b want 1", i_gnt); end
    step();
    rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    total++; if (i_rvalid !== 1'b0) begin bad++;
      $display("FAIL rmid_drop: got i_rvalid=%b want 0", i_rvalid); end
    step();
    rst = 1'b0;
    @(negedge clk);
    total++; if (i_rvalid !== 1'b0) begin bad++;
      $display("FAIL rmid_after: got i_rvalid=%b want 0", i_rvalid); end
    step();
  endtask

  // Random traffic; each master holds its request until granted.
  task automatic test_random(input int n);
    logic        ip, dp, eg_i, eg_d, last_d;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dwe, e_we;
    logic        exp_iv, exp_dv, exp_ie, exp_de;
    logic [31:0] exp_ir, exp_dr;
    do_reset(1);
    ip = 1'b0; dp = 1'b0; last_d = 1'b0; ia = 32'h0; da = 32'h0; dwd = 32'h0; dwe = 4'h0;
    exp_iv = 1'b0; exp_dv = 1'b0; exp_ie = 1'b0; exp_de = 1'b0; exp_ir = 32'h0; exp_dr = 32'h0;
    for (int c = 0; c <= n; c++) begin
      if (c < n && !ip && $urandom_range(0, 3) != 0) begin ip = 1'b1; ia = rand_addr(); end
      if (c < n && !dp && $urandom_range(0, 3) != 0) begin
        dp = 1'b1; da = rand_addr(); dwd = $urandom;
        dwe = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      end
      i_req = ip; i_addr = ia; d_req = dp; d_addr = da; d_we = dwe; d_wdata = dwd;
      eg_i = 1'b0; eg_d = 1'b0;
      if (ip && dp) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        if (last_d) eg_i = 1'b1; else eg_d = 1'b1;
`else
        eg_d = 1'b1;
`endif
      end else begin
        eg_i = ip; eg_d = dp;
      end
      e_we = (eg_d && da[31:2] < 30'd4096) ? dwe : 4'h0;
      @(negedge clk);
      total++; if (i_gnt !== eg_i || d_gnt !== eg_d) begin bad++;
        $display("FAIL rnd_gnt c=%0d: got i=%b d=%b want i=%b d=%b", c, i_gnt, d_gnt, eg_i, eg_d); end
      total++; if (ram_we !== e_we) begin bad++;
        $display("FAIL rnd_we c=%0d: got %b want %b", c, ram_we, e_we); end
      total++; if (i_rvalid !== exp_iv || d_rvalid !== exp_dv) begin bad++;
        $display("FAIL rnd_valid c=%0d: got i=%b d=%b want i=%b d=%b", c, i_rvalid, d_rvalid, exp_iv, exp_dv); end
      if (exp_iv) begin
        total++; if (i_rdata !== exp_ir || i_err !== exp_ie) begin bad++;
          $display("FAIL rnd_iresp c=%0d: got d=%h e=%b want d=%h e=%b", c, i_rdata, i_err, exp_ir, exp_ie); end
      end
      if (exp_dv) begin
        total++; if (d_rdata !== exp_dr || d_err !== exp_de) begin bad++;
          $display("FAIL rnd_dresp c=%0d: got d=%h e=%b want d=%h e=%b", c, d_rdata, d_err, exp_dr, exp_de); end
      end
      exp_iv = eg_i; exp_dv = eg_d;
      if (eg_d) begin
        if (da[31:2] < 30'd4096) begin
          exp_de = 1'b0; exp_dr = ref_mem[da[13:2]];
          for (int b = 0; b < 4; b++)
            if (dwe[b]) ref_mem[da[13:2]][8*b +: 8] = dwd[8*b +: 8];
        end else begin
          exp_de = 1'b1; exp_dr = 32'h0;
        end
        dp = 1'b0; last_d = 1'b1;
      end
      if (eg_i) begin
        if (ia[31:2] < 30'd4096) begin
          exp_ie = 1'b0; exp_ir = ref_mem[ia[13:2]];
        end else begin
          exp_ie = 1'b1; exp_ir = 32'h0;
        end
        ip = 1'b0; last_d = 1'b0;
      end
      step();
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pre_en = 1'b0; pre_addr = 12'h0; pre_data = 32'h0;
    i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    test_reset();
    preload_all();
    test_read();
    test_byte_write();
    test_contention();
    test_out_of_range();
    test_reset_mid();
    test_random(600);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter_2p.md
# ram_arbiter_2p

Two-port arbiter that shares one single-port, byte-write, read-first word RAM between the core's instruction-fetch port and data port in the testbench memory subsystem. Each requester sees a req/gnt/rvalid handshake with one-cycle read latency. The arbiter selects one request per cycle, drives the RAM's `we`/`addr`/`di`, and routes the registered RAM output back to the granted port. It also range-checks addresses and returns an error response for accesses outside the RAM.

## Interface
- `MEM_SIZE_WORDS`, default 4096: RAM depth in 32-bit words; must match the attached RAM.
- `ADDR_WIDTH` (localparam), $clog2(MEM_SIZE_WORDS): RAM word-address width.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `i_req`  in  1  instruction port request.
- `i_addr`  in  32  instruction byte address.
- `i_gnt`  out  1  instruction request accepted this cycle.
- `i_rvalid`  out  1  instruction response valid.
- `i_rdata`  out  32  instruction read data.
- `i_err`  out  1  instruction address out of range; qualified by `i_rvalid`.
- `d_req`  in  1  data port request.
- `d_we`  in  4  data byte write enables; 0 means read.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  data write data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  data response valid; also issued for writes.
- `d_rdata`  out  32  data read data (pre-write contents on writes).
- `d_err`  out  1  data address out of range; qualified by `d_rvalid`.
- `ram_we`  out  4  to RAM `we`.
- `ram_addr`  out  ADDR_WIDTH  to RAM `addr`.
- `ram_di`  out  32  to RAM `di`.
- `ram_dout`  in  32  from RAM `dout`; registered, valid 1 cycle after the address is presented.

## Operation
- Word index is `addr[ADDR_WIDTH+1:2]`. `addr[1:0]` is ignored.
- An address is in range iff `addr[31:2] < MEM_SIZE_WORDS`.
- At most one grant per cycle. `x_gnt` is combinational from `x_req` and the arbiter state. A request is held by its master until granted.
- Granted instruction access: `ram_we=0`, `ram_addr` = instruction word index.
- Granted data access: `ram_we=d_we`, `ram_addr` = data word index, `ram_di=d_wdata`.
- Out-of-range grant:
  - `ram_we` is forced to 0, so no RAM write occurs.
  - The response carries `err=1` and `rdata=0`.
- No grant: `ram_we=0`, `ram_addr=0`, `ram_di=0`.
- Response tracking: registers `resp_sel` (none/instr/data) and `resp_err` capture the grant outcome each cycle.
  - Cycle N+1 asserts `rvalid` only on the port granted in N.
  - `rdata` = `ram_dout`, or 0 when `resp_err`.
  - The other port's `rvalid` stays 0.
- Arbitration (default): fixed priority, data over instruction. When both ports request, data is granted and instruction waits.
- Back-to-back grants to the same or alternating ports are allowed every cycle; throughput is one access per cycle.
- Reset values: all `gnt`, `rvalid`, `err` = 0; `rdata` = 0; `resp_sel` = none; round-robin pointer = instruction.
- While `rst`=1: no grants, and `ram_we=0`.
- Reset asserted in the cycle after a grant: the pending response is dropped and `rvalid` stays 0.

## Timing
- Request-to-grant: 0 cycles (same cycle).
- Grant-to-response: exactly 1 cycle. `rvalid` is a 1-cycle pulse per grant.
- Write followed by a read of the same word in the next cycle: the read returns the new data, because the RAM write lands on the grant-cycle edge.
- Write response `rdata` = old word contents (read-first).
- Simultaneous requests: one port is granted in cycle N and the other in cycle N+1 (if still requesting and no newer higher-priority winner).

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN`
  - Defined: a 1-bit last-winner pointer alternates priority.
    - When both ports request, the port not granted most recently wins.
    - The pointer updates only on a grant.
    - No port waits more than 1 cycle under continuous contention.
  - Undefined: fixed data-over-instruction priority. The pointer logic is not compiled; instruction starvation under continuous `d_req` is permitted.

## Test plan
- Reset then idle: hold `rst` for 3 cycles with requests high.
  - Required: no `gnt`, `ram_we=0`, all `rvalid`=0.
- Read path: preload word 5 = 0xDEADBEEF; `i_req`, `i_addr`=0x14.
  - Required: `i_gnt`=1 in N; `i_rvalid`=1, `i_rdata`=0xDEADBEEF, `i_err`=0 in N+1.
- Byte write: word 2 = 0x11223344; `d_we`=4'b0010, `d_wdata`=0x0000AA00, `d_addr`=0x8.
  - Required: `d_rdata`=0x11223344 at N+1; a read at N+1 returns 0x1122AA44 at N+2.
- Contention:
  - Both ports request continuously for 4 cycles. Default build: 4 data grants, 0 instruction grants. `RAM_ARB_ROUND_ROBIN_EN` build: grants alternate D, I, D, I (pointer reset = instruction last-winner).
  - Both ports request for exactly 1 cycle. Required: data granted in that cycle, instruction granted in the next.
- Out of range: `MEM_SIZE_WORDS`=4096, `d_addr`=0x4000, `d_we`=4'hF.
  - Required: `d_gnt`=1, `ram_we`=0; `d_rvalid`=1, `d_err`=1, `d_rdata`=0 next cycle; RAM contents unchanged.
- Reset mid-operation: assert `rst` the cycle after an `i_gnt`.
  - Required: `i_rvalid` stays 0.
